// File: rtl/regfile_writeback.sv
// regfile_writeback: write-port sequencer for the register file.
// Two producer sources (ALU = 0, load unit = 1) each feed a small FIFO.
// The FIFOs are drained round-robin, one register-file write per cycle.
// After reset, a sweep writes zero into every register before normal operation.
// Optional feature macro: WB_BYPASS_EN adds a combinational read-forwarding port
// (fwd_sel / fwd_hit / fwd_data) over buffered and in-flight writes.
module regfile_writeback #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 2
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_dest,
    input  logic [DW-1:0] alu_result,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_dest,
    input  logic [DW-1:0] mem_result,
    output logic          Write,
    output logic [AW-1:0] select,
    output logic [DW-1:0] data,
    output logic          busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0] fwd_sel,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [AW-1:0]   count_r;
    logic            rr_r;              // 0: ALU has priority, 1: load unit has priority
    logic            write_r;
    logic [AW-1:0]   select_r;
    logic [DW-1:0]   data_r;

    logic [AW-1:0]   fdest_r [2][DEPTH];
    logic [DW-1:0]   fdata_r [2][DEPTH];
    logic [PW-1:0]   wptr_r  [2];
    logic [PW-1:0]   rptr_r  [2];
    logic [CW-1:0]   cnt_r   [2];

    logic [1:0]      in_valid_s;
    logic [AW-1:0]   in_dest_s [2];
    logic [DW-1:0]   in_data_s [2];
    logic [1:0]      ready_s;
    logic [1:0]      push_s;
    logic [1:0]      nonempty_s;
    logic [1:0]      pop_s;
    logic            pop_src_s;
    logic [AW-1:0]   head_dest_s;
    logic [DW-1:0]   head_data_s;

    assign in_valid_s   = {mem_valid, alu_valid};
    assign in_dest_s[0] = alu_dest;
    assign in_dest_s[1] = mem_dest;
    assign in_data_s[0] = alu_result;
    assign in_data_s[1] = mem_result;

    // Handshake: ready depends only on registered state, never on valid.
    always_comb begin
        ready_s    = 2'b00;
        nonempty_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ready_s[i]    = (state_r == RUN) && (cnt_r[i] != CW'(DEPTH));
            nonempty_s[i] = (cnt_r[i] != {CW{1'b0}});
        end
    end

    assign push_s    = in_valid_s & ready_s;
    assign alu_ready = ready_s[0];
    assign mem_ready = ready_s[1];

    // Arbitration: a lone non-empty source wins; a tie goes to the rr pointer.
    always_comb begin
        pop_s = 2'b00;
        if (state_r != RUN) begin
            pop_s = 2'b00;
        end else if (nonempty_s == 2'b11) begin
            pop_s = rr_r ? 2'b10 : 2'b01;
        end else begin
            pop_s = nonempty_s;
        end
    end

    assign pop_src_s   = pop_s[1];
    assign head_dest_s = fdest_r[pop_src_s][rptr_r[pop_src_s]];
    assign head_data_s = fdata_r[pop_src_s][rptr_r[pop_src_s]];

    // FIFO storage: payload written on accepted push, no reset needed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                fdest_r[i][wptr_r[i]] <= in_dest_s[i];
                fdata_r[i][wptr_r[i]] <= in_data_s[i];
            end
        end
    end

    // FIFO pointers and occupancy; reset discards every buffered entry.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                wptr_r[i] <= {PW{1'b0}};
                rptr_r[i] <= {PW{1'b0}};
                cnt_r[i]  <= {CW{1'b0}};
            end else begin
                wptr_r[i] <= wptr_r[i] + {{(PW-1){1'b0}}, push_s[i]};
                rptr_r[i] <= rptr_r[i] + {{(PW-1){1'b0}}, pop_s[i]};
                cnt_r[i]  <= cnt_r[i] + {{PW{1'b0}}, push_s[i]} - {{PW{1'b0}}, pop_s[i]};
            end
        end
    end

    // Round-robin pointer moves only when both sources competed.
    always_ff @(posedge clock) begin
        if (rst) begin
            rr_r <= 1'b0;
        end else if ((state_r == RUN) && (nonempty_s == 2'b11)) begin
            rr_r <= pop_s[0];
        end else begin
            rr_r <= rr_r;
        end
    end

    // Next-state: clear sweep ends after the last register is written.
    always_comb begin
        state_s = state_r;
        case (state_r)
            CLEAR:   state_s = (count_r == {AW{1'b1}}) ? RUN : CLEAR;
            RUN:     state_s = RUN;
            default: state_s = CLEAR;
        endcase
    end

    // State, sweep counter and registered register-file write port.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r  <= CLEAR;
            count_r  <= {AW{1'b0}};
            write_r  <= 1'b0;
            select_r <= {AW{1'b0}};
            data_r   <= {DW{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                CLEAR: begin
                    write_r  <= 1'b1;
                    select_r <= count_r;
                    data_r   <= {DW{1'b0}};
                    count_r  <= count_r + AW'(1);
                end
                RUN: begin
                    if (pop_s != 2'b00) begin
                        write_r  <= 1'b1;
                        select_r <= head_dest_s;
                        data_r   <= head_data_s;
                    end else begin
                        write_r  <= 1'b0;
                    end
                end
                default: begin
                    write_r <= 1'b0;
                end
            endcase
        end
    end

    assign Write  = write_r;
    assign select = select_r;
    assign data   = data_r;
    assign busy   = (state_r == CLEAR);

`ifdef WB_BYPASS_EN
    logic [1:0]    src_hit_s;
    logic [CW-1:0] src_pos_s  [2];
    logic [DW-1:0] src_data_s [2];
    logic [PW-1:0] idx_s;
    logic [CW:0]   slot_s     [2];

    function automatic logic [CW:0] min_ext(input logic [CW:0] a, input logic [CW:0] b);
        return (a < b) ? a : b;
    endfunction

    // Youngest matching entry per source, then the one written later wins.
    // Write slot of entry k is k plus the interleaved entries of the other source ahead of it.
    always_comb begin
        src_hit_s = 2'b00;
        idx_s     = {PW{1'b0}};
        fwd_hit   = 1'b0;
        fwd_data  = {DW{1'b0}};
        for (int i = 0; i < 2; i++) begin
            src_pos_s[i]  = {CW{1'b0}};
            src_data_s[i] = {DW{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                idx_s = rptr_r[i] + PW'(k);
                if ((CW'(k) < cnt_r[i]) && (fdest_r[i][idx_s] == fwd_sel)) begin
                    src_hit_s[i]  = 1'b1;
                    src_pos_s[i]  = CW'(k);
                    src_data_s[i] = fdata_r[i][idx_s];
                end
            end
        end
        slot_s[0] = {1'b0, src_pos_s[0]}
                  + min_ext({1'b0, src_pos_s[0]} + {{CW{1'b0}}, rr_r}, {1'b0, cnt_r[1]});
        slot_s[1] = {1'b0, src_pos_s[1]}
                  + min_ext({1'b0, src_pos_s[1]} + {{CW{1'b0}}, ~rr_r}, {1'b0, cnt_r[0]});
        if (state_r == CLEAR) begin
            fwd_hit  = 1'b1;
            fwd_data = {DW{1'b0}};
        end else if (src_hit_s == 2'b11) begin
            fwd_hit  = 1'b1;
            fwd_data = (slot_s[1] > slot_s[0]) ? src_data_s[1] : src_data_s[0];
        end else if (src_hit_s[0]) begin
            fwd_hit  = 1'b1;
            fwd_data = src_data_s[0];
        end else if (src_hit_s[1]) begin
            fwd_hit  = 1'b1;
            fwd_data = src_data_s[1];
        end else if (write_r && (select_r == fwd_sel)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_r;
        end else begin
            fwd_hit  = 1'b0;
            fwd_data = {DW{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback: clear sweep, single write latency,
// two-source arbitration with backpressure, reset mid-operation, optional forwarding.
module tb_regfile_writeback;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, mem_valid, mem_ready;
    logic [AW-1:0] alu_dest, mem_dest, select;
    logic [DW-1:0] alu_result, mem_result, data;
    logic          Write, busy;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] fwd_sel;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    int errors = 0;
    int checks = 0;
    logic [AW+DW-1:0] wlog [$];

    always #5 clk = ~clk;

    regfile_writeback #(.DW(DW), .AW(AW), .DEPTH(2)) dut (
        .clock(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_result(alu_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_result(mem_result),
        .Write(Write), .select(select), .data(data), .busy(busy)
`ifdef WB_BYPASS_EN
        , .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    // Log every register-file write, sampled mid-cycle.
    always @(negedge clk) begin
        if (Write === 1'b1) wlog.push_back({select, data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]      av [3];
        logic [15:0]      mv [3];
        logic [AW+DW-1:0] ex [6];
        logic [1:0]       mrec;
        logic             mr [4];
        int               ai, mi, macc;
        logic             a_acc, m_acc;

        av = '{16'h0001, 16'h0002, 16'h0003};
        mv = '{16'h000A, 16'h000B, 16'h000C};
        ex = '{{4'd1, 16'h0001}, {4'd2, 16'h000A}, {4'd1, 16'h0002},
               {4'd2, 16'h000B}, {4'd1, 16'h0003}, {4'd2, 16'h000C}};

        rst = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_dest = 4'd0; mem_dest = 4'd0;
        alu_result = 16'h0000; mem_result = 16'h0000;
`ifdef WB_BYPASS_EN
        fwd_sel = 4'd5;
`endif

        // Reset state
        step();
        check("rst_write", 32'(Write), 32'd0);
        check("rst_select", 32'(select), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
`ifdef WB_BYPASS_EN
        check("clr_fwd_hit", 32'(fwd_hit), 32'd1);
        check("clr_fwd_data", 32'(fwd_data), 32'd0);
`endif

        // Clear sweep: select 0..15, data 0, busy falls with the last write
        rst = 1'b0;
        wlog.delete();
        for (int i = 0; i < 16; i++) begin
            step();
            check("clr_write", 32'(Write), 32'd1);
            check("clr_select", 32'(select), 32'(i));
            check("clr_data", 32'(data), 32'd0);
            check("clr_busy", 32'(busy), (i < 15) ? 32'd1 : 32'd0);
        end
        check("run_alu_ready", 32'(alu_ready), 32'd1);
        check("run_mem_ready", 32'(mem_ready), 32'd1);

        // Single ALU push: write appears two cycles after it is offered
        alu_valid = 1'b1; alu_dest = 4'd3; alu_result = 16'hBEEF;
        step();
        alu_valid = 1'b0;
        check("single_w_early", 32'(Write), 32'd0);
        step();
        check("single_write", 32'(Write), 32'd1);
        check("single_select", 32'(select), 32'd3);
        check("single_data", 32'(data), 32'hBEEF);
        step();
        check("single_idle", 32'(Write), 32'd0);
        check("single_hold_sel", 32'(select), 32'd3);
        check("single_hold_data", 32'(data), 32'hBEEF);
        check("sweep_count", 32'(wlog.size()), 32'd17);
        for (int i = 0; i < 16; i++) check("sweep_log", 32'(wlog[i]), 32'({AW'(i), 16'h0000}));

        // Both sources streaming: alternation, order kept, mem backpressure
        wlog.delete();
        ai = 0; mi = 0; macc = -1;
        for (int c = 0; c < 20; c++) begin
            alu_valid = (ai < 3); alu_dest = 4'd1; alu_result = av[(ai < 3) ? ai : 0];
            mem_valid = (mi < 3); mem_dest = 4'd2; mem_result = mv[(mi < 3) ? mi : 0];
            if (c < 4) mr[c] = mem_ready;
            if (c == 3) macc = mi;
            a_acc = alu_valid && alu_ready;
            m_acc = mem_valid && mem_ready;
            step();
            if (a_acc) ai++;
            if (m_acc) mi++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        mrec = {mr[1], mr[0]};
        check("bp_ready_c01", 32'(mrec), 32'd3);
        check("bp_ready_full", 32'(mr[2]), 32'd0);
        check("bp_ready_freed", 32'(mr[3]), 32'd1);
        check("bp_accepted_at_full", 32'(macc), 32'd2);
        check("stream_alu_acc", 32'(ai), 32'd3);
        check("stream_mem_acc", 32'(mi), 32'd3);
        check("stream_count", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wlog.size()) check("stream_order", 32'(wlog[i]), 32'(ex[i]));
            else check("stream_missing", 32'd0, 32'(ex[i]));
        end

        // Reset with entries buffered: none of them may ever be written
        alu_valid = 1'b1; alu_dest = 4'd9; alu_result = 16'h1111;
        mem_valid = 1'b1; mem_dest = 4'd10; mem_result = 16'h2222;
        repeat (4) step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        step();
        wlog.delete();
        check("mid_rst_write", 32'(Write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_ready", 32'(alu_ready), 32'd0);
        rst = 1'b0;
        repeat (22) step();
        check("mid_rst_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < wlog.size()) check("mid_rst_sweep", 32'(wlog[i]), 32'({AW'(i), 16'h0000}));
            else check("mid_rst_missing", 32'd1, 32'd0);
        end
        check("mid_rst_idle", 32'(Write), 32'd0);

`ifdef WB_BYPASS_EN
        // Forwarding: ALU then load unit both target register 5
        fwd_sel = 4'd5;
        alu_valid = 1'b1; alu_dest = 4'd5; alu_result = 16'h0011;
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_dest = 4'd5; mem_result = 16'h0022;
        check("fwd_alu_hit", 32'(fwd_hit), 32'd1);
        check("fwd_alu_data", 32'(fwd_data), 32'h0011);
        step();
        mem_valid = 1'b0;
        check("fwd_young_hit", 32'(fwd_hit), 32'd1);
        check("fwd_young_data", 32'(fwd_data), 32'h0022);
        step();
        check("fwd_port_hit", 32'(fwd_hit), 32'd1);
        check("fwd_port_data", 32'(fwd_data), 32'h0022);
        step();
        check("fwd_drained", 32'(fwd_hit), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
